// File: rtl/mem_stage_pkg.sv
// Shared definitions for the data-memory access stage: access-size
// encodings, FSM state encoding, wait-counter width and small helpers
// used by both the top level and the lane-alignment logic.
package mem_stage_pkg;

    // Width of the wait-state counter; WAIT_CYCLES must fit in it (0..15).
    localparam int CNT_W = 4;

    // Access-size encodings carried on req_size.
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // Access sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Fold the reserved size code 2'b11 onto a word access so the rest of
    // the datapath only ever sees the three legal encodings.
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == 2'b11) ? SIZE_WORD : size;
    endfunction

    // A half access is misaligned on an odd address, a word access on any
    // address that is not a multiple of four. Byte accesses never are.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        if (size == SIZE_HALF) begin
            mis = addr_lo[0];
        end else if (size == SIZE_WORD) begin
            mis = (addr_lo != 2'b00);
        end
        return mis;
    endfunction

endpackage

// File: rtl/load_store_align.sv
// Combinational lane steering for the data-memory stage.
// Store side: byte-lane enables plus write data replicated onto every lane
// so that whichever lanes are enabled pick up the right bytes.
// Load side: extracts the addressed byte/half from the read word and
// sign- or zero-extends it to 32 bits; word loads pass straight through.
module load_store_align
    import mem_stage_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_signed,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_lane,
    output logic [31:0] load_data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Lane enables, replicated write data and extended load data.
    always_comb begin
        // NOTE: every output gets a default first so no path through the
        // case leaves a variable unassigned, which would infer a latch.
        byte_en    = 4'b0000;
        wdata_lane = 32'h0;
        load_data  = 32'h0;
        lane_b     = 8'h0;
        lane_h     = 16'h0;

        unique case (size)
            SIZE_BYTE: begin
                byte_en    = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
                unique case (addr_lo)
                    2'd0: lane_b = rword[7:0];
                    2'd1: lane_b = rword[15:8];
                    2'd2: lane_b = rword[23:16];
                    2'd3: lane_b = rword[31:24];
                endcase
                load_data = is_signed ? {{24{lane_b[7]}}, lane_b}
                                      : {24'h0, lane_b};
            end
            SIZE_HALF: begin
                byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
                lane_h     = addr_lo[1] ? rword[31:16] : rword[15:0];
                load_data  = is_signed ? {{16{lane_h[15]}}, lane_h}
                                       : {16'h0, lane_h};
            end
            default: begin
                byte_en    = 4'b1111;
                wdata_lane = wdata;
                load_data  = rword;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_stage.sv
// Data-memory access stage: accepts one load/store at a time over a
// valid/ready handshake, waits WAIT_CYCLES extra cycles, performs the
// byte/half/word access on an internal word array and presents the
// registered, extended load result for one resp_valid cycle.
// Optional feature: define MEM_MISALIGN_TRAP_EN to trap misaligned
// accesses (no write, zero data, misalign_err raised with resp_valid).
// Without it, low address bits are forced to the natural alignment.
module data_mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        busy,
    output logic        misalign_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;

    // Latched request; only the address bits that select a byte inside
    // the array are kept, so addresses wrap modulo DEPTH_WORDS*4.
    logic              we_q;
    logic              signed_q;
    logic [1:0]        size_q;
    logic [AW+1:0]     addr_q;
    logic [31:0]       wdata_q;

    logic [31:0]       rdata_q;
    logic              err_q;

    logic [31:0]       mem [DEPTH_WORDS];

    logic              accept;
    logic              access;
    logic              misaligned;
    logic [1:0]        lo_eff;
    logic [AW-1:0]     word_idx;
    logic [31:0]       rword;
    logic [3:0]        byte_en;
    logic [31:0]       wdata_lane;
    logic [31:0]       load_data;
    logic              do_write;

    // Upper address bits deliberately take no part in the access.
    logic              unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:AW+2];

    assign accept = (state_q == ST_IDLE) && req_valid;
    assign access = (state_q == ST_WAIT) && (cnt_q == '0);

`ifdef MEM_MISALIGN_TRAP_EN
    assign misaligned = is_misaligned(size_q, addr_q[1:0]);
    assign lo_eff     = addr_q[1:0];
`else
    assign misaligned = 1'b0;
    assign lo_eff     = (size_q == SIZE_HALF) ? {addr_q[1], 1'b0} :
                        (size_q == SIZE_WORD) ? 2'b00 : addr_q[1:0];
`endif

    assign word_idx = addr_q[AW+1:2];
    assign rword    = mem[word_idx];
    assign do_write = access && we_q && !misaligned;

    load_store_align u_align (
        .addr_lo    (lo_eff),
        .size       (size_q),
        .is_signed  (signed_q),
        .wdata      (wdata_q),
        .rword      (rword),
        .byte_en    (byte_en),
        .wdata_lane (wdata_lane),
        .load_data  (load_data)
    );

    // State register; reset drops any in-flight request.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of process order.
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> WAIT on accept, WAIT -> RESP when the
    // counter has run out, RESP -> IDLE after its single cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept) state_d = ST_WAIT;
            ST_WAIT: if (cnt_q == '0) state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Request latch and wait counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we_q     <= 1'b0;
            signed_q <= 1'b0;
            size_q   <= SIZE_BYTE;
            addr_q   <= '0;
            wdata_q  <= 32'h0;
            cnt_q    <= '0;
        end else if (accept) begin
            we_q     <= req_we;
            signed_q <= req_signed;
            size_q   <= norm_size(req_size);
            addr_q   <= req_addr[AW+1:0];
            wdata_q  <= req_wdata;
            cnt_q    <= CNT_W'(WAIT_CYCLES);
        end else if ((state_q == ST_WAIT) && (cnt_q != '0)) begin
            cnt_q    <= cnt_q - 1'b1;
        end
    end

    // Response data and error flag, captured at the access edge and held
    // until the next access completes. Stores and traps return zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else if (access) begin
            rdata_q <= (we_q || misaligned) ? 32'h0 : load_data;
            err_q   <= misaligned;
        end
    end

    // Word array with per-lane write enables.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset; clearing it would turn a plain RAM
        // into a register file and its contents are undefined until written.
        if (do_write) begin
            for (int l = 0; l < 4; l++) begin
                if (byte_en[l]) begin
                    mem[word_idx][8*l +: 8] <= wdata_lane[8*l +: 8];
                end
            end
        end
    end

    assign req_ready    = (state_q == ST_IDLE);
    assign busy         = (state_q != ST_IDLE);
    assign resp_valid   = (state_q == ST_RESP);
    assign resp_rdata   = rdata_q;
    assign misalign_err = resp_valid && err_q;

endmodule

// File: tb/tb_data_mem_stage.sv
// Self-checking bench for data_mem_stage. Each issued request pushes its
// expected response onto a scoreboard queue; a monitor pops and compares
// on every resp_valid, including response latency.
module tb_data_mem_stage;

    localparam int DEPTH_WORDS = 256;
    localparam int WAIT_CYCLES = 2;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_signed;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        busy;
    logic        misalign_err;

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        err;
        logic        not_equal;
        int          acc_cyc;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;
    int n_acc    = 0;
    int n_resp   = 0;
    int cyc      = 0;

`ifdef MEM_MISALIGN_TRAP_EN
    localparam logic TRAP = 1'b1;
`else
    localparam logic TRAP = 1'b0;
`endif

    data_mem_stage #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_size     (req_size),
        .req_signed   (req_signed),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .busy         (busy),
        .misalign_err (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor: compare every response against the queue head.
    always @(negedge clk) begin
        if (resp_valid) begin
            n_resp++;
            if (sb.size() == 0) begin
                check("unexpected_resp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.not_equal) begin
                    check({e.tag, "_not_old"}, 32'(resp_rdata != e.rdata), 32'd1);
                end else begin
                    check({e.tag, "_rdata"}, resp_rdata, e.rdata);
                end
                check({e.tag, "_err"}, 32'(misalign_err), 32'(e.err));
                check({e.tag, "_latency"}, 32'(cyc - e.acc_cyc), 32'(WAIT_CYCLES + 1));
            end
        end
    end

    // Issue one request, holding req_valid until its response appears.
    task automatic do_req(input string tag, input logic we,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] size, input logic sgn,
                          input logic [31:0] exp_rdata, input logic exp_err,
                          input logic not_equal);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check({tag, "_ready_timeout"}, 32'd0, 32'd1);
            return;
        end
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wdata;
        req_size   = size;
        req_signed = sgn;
        req_valid  = 1'b1;
        @(posedge clk);
        #1;
        e.tag       = tag;
        e.rdata     = exp_rdata;
        e.err       = exp_err;
        e.not_equal = not_equal;
        e.acc_cyc   = cyc;
        sb.push_back(e);
        n_acc++;
        n = 0;
        do begin
            @(negedge clk);
            check({tag, "_busy"}, 32'(busy), 32'd1);
            n++;
        end while (!resp_valid && n < 40);
        if (!resp_valid) check({tag, "_resp_timeout"}, 32'd0, 32'd1);
        req_valid = 1'b0;
    endtask

    initial begin
        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        req_size   = 2'b00;
        req_signed = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_rdata", resp_rdata, 32'h0);
        check("rst_err", 32'(misalign_err), 32'd0);
        reset_n = 1'b1;

        // Store accepted, then reset during WAIT: it must be dropped.
        @(negedge clk);
        req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'hDEADBEEF;
        req_size = 2'b10; req_signed = 1'b0; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("midwait_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("midwait_rst_valid", 32'(resp_valid), 32'd0);
        check("midwait_rst_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (WAIT_CYCLES + 4) @(negedge clk);
        check("midwait_after_ready", 32'(req_ready), 32'd1);
        do_req("ld_dropped", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'hDEADBEEF, 1'b0, 1'b1);

        // Word round trip.
        do_req("st_w20", 1'b1, 32'h20, 32'h12345678, 2'b10, 1'b0, 32'h0, 1'b0, 1'b0);
        do_req("ld_w20", 1'b0, 32'h20, 32'h0, 2'b10, 1'b1, 32'h12345678, 1'b0, 1'b0);

        // Byte loads and lane preservation.
        do_req("ld_bs23", 1'b0, 32'h23, 32'h0, 2'b00, 1'b1, 32'h00000012, 1'b0, 1'b0);
        do_req("st_b21", 1'b1, 32'h21, 32'h00000080, 2'b00, 1'b0, 32'h0, 1'b0, 1'b0);
        do_req("ld_bs21", 1'b0, 32'h21, 32'h0, 2'b00, 1'b1, 32'hFFFFFF80, 1'b0, 1'b0);
        do_req("ld_bu21", 1'b0, 32'h21, 32'h0, 2'b00, 1'b0, 32'h00000080, 1'b0, 1'b0);
        do_req("ld_w20b", 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 32'h12348078, 1'b0, 1'b0);
        do_req("ld_sz3", 1'b0, 32'h20, 32'h0, 2'b11, 1'b1, 32'h12348078, 1'b0, 1'b0);

        // Half store and extension.
        do_req("st_w40", 1'b1, 32'h40, 32'h0000CAFE, 2'b10, 1'b0, 32'h0, 1'b0, 1'b0);
        do_req("st_h42", 1'b1, 32'h42, 32'h1234BEEF, 2'b01, 1'b0, 32'h0, 1'b0, 1'b0);
        do_req("ld_hs42", 1'b0, 32'h42, 32'h0, 2'b01, 1'b1, 32'hFFFFBEEF, 1'b0, 1'b0);
        do_req("ld_hu42", 1'b0, 32'h42, 32'h0, 2'b01, 1'b0, 32'h0000BEEF, 1'b0, 1'b0);
        do_req("ld_w40", 1'b0, 32'h40, 32'h0, 2'b10, 1'b0, 32'hBEEFCAFE, 1'b0, 1'b0);

        // Misaligned word store.
        do_req("st_w30", 1'b1, 32'h30, 32'h11223344, 2'b10, 1'b0, 32'h0, 1'b0, 1'b0);
        do_req("st_w31", 1'b1, 32'h31, 32'hAAAAAAAA, 2'b10, 1'b0, 32'h0, TRAP, 1'b0);
        do_req("ld_w30", 1'b0, 32'h30, 32'h0, 2'b10, 1'b0,
               TRAP ? 32'h11223344 : 32'hAAAAAAAA, 1'b0, 1'b0);

        // Address wrap.
        do_req("st_w400", 1'b1, 32'h400, 32'h00000055, 2'b10, 1'b0, 32'h0, 1'b0, 1'b0);
        do_req("ld_w0", 1'b0, 32'h0, 32'h0, 2'b10, 1'b0, 32'h00000055, 1'b0, 1'b0);

        repeat (WAIT_CYCLES + 4) @(negedge clk);
        check("resp_count", 32'(n_resp), 32'(n_acc));
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
